dsa_img_loader: RTL and testbench

- Upstream stage of the bilinear DSA. Receives a framed input image as a byte stream from the board's UART receiver and writes it into the shared image memory at the input-image region.
- On a verified frame it publishes the image dimensions and pulses load_done, which the top uses as the core start in place of the debounced start switch.
- Frame format, in order:
  - magic byte 0xA5
  - width, 16-bit little-endian
  - height, 16-bit little-endian
  - W*H pixel bytes in row-major order
  - checksum byte: sum of all pixel bytes mod 256

---
 rtl/dsa_img_loader_pkg.sv | 34 +++
 rtl/dsa_img_loader_if.sv | 24 ++
 rtl/dsa_img_loader_gap_timer.sv | 28 ++
 rtl/dsa_img_loader.sv | 168 ++++++++++++++++
 tb/tb_dsa_img_loader.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dsa_img_loader_pkg.sv
// Shared types for the DSA image loader: frame magic, FSM states and error codes.
// Also provides the end-of-image address helper used by the size check.
package dsa_loader_pkg;

  localparam logic [7:0] MAGIC = 8'hA5;

  typedef enum logic [3:0] {
    IDLE,
    HDR_W0,
    HDR_W1,
    HDR_H0,
    HDR_H1,
    CHECK,
    PAYLOAD,
    CSUM,
    DONE
  } loader_state_t;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_HDR     = 3'd1,
    ERR_SIZE    = 3'd2,
    ERR_CSUM    = 3'd3,
    ERR_TIMEOUT = 3'd4
  } loader_err_t;

  // One past the last byte the image would occupy; 33 bits so the sum cannot wrap.
  function automatic logic [32:0] frame_end(input logic [31:0] base,
                                            input logic [15:0] w,
                                            input logic [15:0] h);
    return {1'b0, base} + {1'b0, 32'(w) * 32'(h)};
  endfunction

endpackage

// File: rtl/dsa_img_loader_if.sv
// Byte stream from the UART receiver plus the write port into the shared image memory.
// The loader sits on the slave side; the source/observer sits on the master side.
interface dsa_img_loader_if #(
  parameter int AW = 19
);
  logic [7:0]    s_data;
  logic          s_valid;
  logic          s_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;

  modport master (
    output s_data, s_valid,
    input  s_ready,
    input  mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  s_data, s_valid,
    output s_ready,
    output mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dsa_img_loader_gap_timer.sv
// Counts idle cycles since the last accepted byte while a frame is open.
// expired is raised on the GAP_CYC-th idle cycle, never in a cycle that carries a byte.
module byte_gap_timer #(
  parameter int GAP_CYC = 5_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic kick,
  output logic expired
);

  localparam int CW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(GAP_CYC - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || !run || kick) begin
      cnt <= '0;
    end else if (cnt != LAST) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = run && !kick && (cnt == LAST);

endmodule

// File: rtl/dsa_img_loader.sv
// Parses a framed image from the UART byte stream, writes the pixels into image memory
// and, once the checksum matches, publishes the dimensions and pulses load_done.
module dsa_img_loader
  import dsa_loader_pkg::*;
#(
  parameter int            AW        = 19,
  parameter int            MAX_DIM   = 1024,
  parameter logic [AW-1:0] BASE_ADDR = '0,
  parameter int            GAP_CYC   = 5_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  dsa_img_loader_if.slave       bus,
  output logic [15:0]           o_in_w,
  output logic [15:0]           o_in_h,
  output logic                  o_img_valid,
  output logic                  load_done,
  output logic                  o_busy,
  output logic [2:0]            o_err,
  output logic [31:0]           o_byte_count
);

  localparam logic [15:0] MAX_D  = 16'(MAX_DIM);
  localparam logic [32:0] DEPTH  = 33'(1) << AW;
  localparam logic [31:0] BASE32 = 32'(BASE_ADDR);

  loader_state_t state, state_nxt;
  loader_err_t   err_q, err_nxt;
  logic          set_err;
  logic          accept;
  logic          expired;
  logic [15:0]   w_sh, h_sh;
  logic [31:0]   total, pix_cnt;
  logic [7:0]    csum;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [7:0]    wdata_q;

  assign bus.s_ready = (state != CHECK) && (state != DONE);
  assign accept      = bus.s_valid && bus.s_ready;

  byte_gap_timer #(
    .GAP_CYC(GAP_CYC)
  ) u_gap (
    .clk    (clk),
    .rst    (rst),
    .run    (state != IDLE),
    .kick   (accept),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    set_err   = 1'b0;
    err_nxt   = ERR_NONE;
    case (state)
      IDLE:    if (accept && bus.s_data == MAGIC) state_nxt = HDR_W0;
      HDR_W0:  if (accept) state_nxt = HDR_W1;
      HDR_W1:  if (accept) state_nxt = HDR_H0;
      HDR_H0:  if (accept) state_nxt = HDR_H1;
      HDR_H1:  if (accept) state_nxt = CHECK;
      CHECK: begin
        if (w_sh == 16'd0 || h_sh == 16'd0 || w_sh > MAX_D || h_sh > MAX_D) begin
          state_nxt = IDLE;
          set_err   = 1'b1;
          err_nxt   = ERR_HDR;
        end else if (frame_end(BASE32, w_sh, h_sh) > DEPTH) begin
          state_nxt = IDLE;
          set_err   = 1'b1;
          err_nxt   = ERR_SIZE;
        end else begin
          state_nxt = PAYLOAD;
        end
      end
      PAYLOAD: if (accept && pix_cnt == total - 32'd1) state_nxt = CSUM;
      CSUM: begin
        if (accept) begin
          if (bus.s_data == csum) begin
            state_nxt = DONE;
          end else begin
            state_nxt = IDLE;
            set_err   = 1'b1;
            err_nxt   = ERR_CSUM;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // expired is never high alongside an accepted byte, so a late byte always wins
    if (expired && (state inside {HDR_W0, HDR_W1, HDR_H0, HDR_H1, PAYLOAD, CSUM})) begin
      state_nxt = IDLE;
      set_err   = 1'b1;
      err_nxt   = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_sh         <= '0;
      h_sh         <= '0;
      total        <= '0;
      pix_cnt      <= '0;
      csum         <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      err_q        <= ERR_NONE;
      o_in_w       <= '0;
      o_in_h       <= '0;
      o_img_valid  <= 1'b0;
      load_done    <= 1'b0;
      o_byte_count <= '0;
    end else begin
      we_q      <= 1'b0;
      load_done <= 1'b0;
      if (accept) begin
        o_byte_count <= o_byte_count + 32'd1;
        case (state)
          HDR_W0:  w_sh[7:0]  <= bus.s_data;
          HDR_W1:  w_sh[15:8] <= bus.s_data;
          HDR_H0:  h_sh[7:0]  <= bus.s_data;
          HDR_H1:  h_sh[15:8] <= bus.s_data;
          default: ;
        endcase
      end
      if (state == CHECK && state_nxt == PAYLOAD) begin
        total       <= 32'(w_sh) * 32'(h_sh);
        pix_cnt     <= '0;
        csum        <= '0;
        o_img_valid <= 1'b0;
      end
      if (state == PAYLOAD && accept) begin
        we_q    <= 1'b1;
        addr_q  <= BASE_ADDR + pix_cnt[AW-1:0];
        wdata_q <= bus.s_data;
        csum    <= csum + bus.s_data;
        pix_cnt <= pix_cnt + 32'd1;
      end
      if (set_err) begin
        err_q <= err_nxt;
      end
      if (state == DONE) begin
        o_in_w      <= w_sh;
        o_in_h      <= h_sh;
        o_img_valid <= 1'b1;
        load_done   <= 1'b1;
        err_q       <= ERR_NONE;
      end
    end
  end

  // A write pending from the previous cycle is dropped if reset lands on it
  assign bus.mem_we    = we_q && !rst;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign o_busy        = (state != IDLE);
  assign o_err         = err_q;

endmodule

// File: tb/tb_dsa_img_loader.sv
// Self-checking bench for dsa_img_loader: frame-level reference model with random pixels,
// directed header/size/checksum/timeout/reset scenarios and a write/handshake monitor.
module tb_dsa_img_loader;

  localparam int            AW      = 19;
  localparam int            MAX_DIM = 1024;
  localparam logic [AW-1:0] BASE    = '0;
  localparam int            GAP     = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] o_in_w, o_in_h;
  logic        o_img_valid, load_done, o_busy;
  logic [2:0]  o_err;
  logic [31:0] o_byte_count;

  dsa_img_loader_if #(.AW(AW)) dut_if ();

  dsa_img_loader #(
    .AW       (AW),
    .MAX_DIM  (MAX_DIM),
    .BASE_ADDR(BASE),
    .GAP_CYC  (GAP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (dut_if),
    .o_in_w      (o_in_w),
    .o_in_h      (o_in_h),
    .o_img_valid (o_img_valid),
    .load_done   (load_done),
    .o_busy      (o_busy),
    .o_err       (o_err),
    .o_byte_count(o_byte_count)
  );

  always #5 clk = ~clk;

  typedef struct { int cyc; logic [7:0] data; } acc_t;
  typedef struct { int cyc; logic [AW-1:0] addr; logic [7:0] data; } wr_t;

  acc_t acc_q[$];
  wr_t  wr_q[$];
  int   cyc = 0;
  int   done_cnt = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  logic [15:0] exp_w, exp_h;
  logic        exp_valid;
  logic [2:0]  exp_err;
  int          exp_bytes;
  int          exp_done = 0;
  logic [7:0]  fixed_pix[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && dut_if.s_valid && dut_if.s_ready) acc_q.push_back('{cyc, dut_if.s_data});
    if (dut_if.mem_we) wr_q.push_back('{cyc, dut_if.mem_addr, dut_if.mem_wdata});
    if (load_done) done_cnt++;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=no_finish expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    dut_if.s_data  = b;
    dut_if.s_valid = 1'b1;
    @(negedge clk);
    while (!dut_if.s_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("s_ready_wait", 64'(waited < 20), 64'(1));
    @(posedge clk);
    #1;
    dut_if.s_valid = 1'b0;
  endtask

  task automatic model_reset();
    exp_w     = '0;
    exp_h     = '0;
    exp_valid = 1'b0;
    exp_err   = 3'd0;
    exp_bytes = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic check_status(input string tag);
    checkOutput({tag, ":o_err"}, 64'(o_err), 64'(exp_err));
    checkOutput({tag, ":o_img_valid"}, 64'(o_img_valid), 64'(exp_valid));
    checkOutput({tag, ":o_in_w"}, 64'(o_in_w), 64'(exp_w));
    checkOutput({tag, ":o_in_h"}, 64'(o_in_h), 64'(exp_h));
    checkOutput({tag, ":o_byte_count"}, 64'(o_byte_count), 64'(exp_bytes));
    checkOutput({tag, ":load_done_pulses"}, 64'(done_cnt), 64'(exp_done));
    checkOutput({tag, ":o_busy"}, 64'(o_busy), 64'(0));
    checkOutput({tag, ":s_ready"}, 64'(dut_if.s_ready), 64'(1));
  endtask

  // Sends one frame; stall_len idle cycles are inserted before payload byte stall_pos.
  task automatic applyStimulus(input string tag, input int w, input int h, input logic [7:0] csum_xor,
                               input int gap_max, input int stall_pos, input int stall_len);
    logic [7:0] pix[$];
    logic [7:0] hdr[5];
    logic [7:0] sum = 8'd0;
    int  n, acc_base, wr_base, sent_pix, n_obs;
    bit  hdr_bad, size_bad, timed_out;
    logic [63:0] obs, expv;

    hdr_bad  = (w == 0) || (h == 0) || (w > MAX_DIM) || (h > MAX_DIM);
    size_bad = !hdr_bad && (64'(BASE) + 64'(w) * 64'(h) > (64'(1) << AW));
    n = (hdr_bad || size_bad) ? 0 : w * h;
    if (n > 0 && fixed_pix.size() == n) pix = fixed_pix;
    else for (int i = 0; i < n; i++) pix.push_back(8'($urandom_range(0, 255)));
    fixed_pix.delete();
    foreach (pix[i]) sum = sum + pix[i];

    hdr[0] = 8'hA5;
    hdr[1] = 8'(w);
    hdr[2] = 8'(w >> 8);
    hdr[3] = 8'(h);
    hdr[4] = 8'(h >> 8);
    acc_base  = acc_q.size();
    wr_base   = wr_q.size();
    sent_pix  = n;
    timed_out = 1'b0;

    for (int i = 0; i < 5; i++) begin
      idle($urandom_range(0, gap_max));
      send_byte(hdr[i]);
    end
    for (int k = 0; k < n; k++) begin
      if (k == stall_pos && stall_len > 0) begin
        if (stall_len >= GAP) begin
          idle(GAP - 1);
          checkOutput({tag, ":busy_before_expiry"}, 64'(o_busy), 64'(1));
          checkOutput({tag, ":err_before_expiry"}, 64'(o_err), 64'(exp_err));
          idle(1);
          exp_err   = 3'd4;
          exp_valid = 1'b0;
          checkOutput({tag, ":err_at_expiry"}, 64'(o_err), 64'(exp_err));
          checkOutput({tag, ":busy_at_expiry"}, 64'(o_busy), 64'(0));
          timed_out = 1'b1;
          sent_pix  = k;
          break;
        end
        idle(stall_len);
      end else begin
        idle($urandom_range(0, gap_max));
      end
      send_byte(pix[k]);
    end
    if (n > 0 && !timed_out) begin
      idle($urandom_range(0, gap_max));
      send_byte(sum ^ csum_xor);
    end

    exp_bytes += 5 + sent_pix + ((n > 0 && !timed_out) ? 1 : 0);
    if (hdr_bad) exp_err = 3'd1;
    else if (size_bad) exp_err = 3'd2;
    else if (!timed_out) begin
      exp_valid = 1'b0;
      if (csum_xor != 8'd0) exp_err = 3'd3;
      else begin
        exp_err   = 3'd0;
        exp_w     = 16'(w);
        exp_h     = 16'(h);
        exp_valid = 1'b1;
        exp_done++;
      end
    end

    idle(3);
    check_status(tag);
    n_obs = wr_q.size() - wr_base;
    checkOutput({tag, ":write_count"}, 64'(n_obs), 64'(sent_pix));
    if (gap_max == 0 && n > 0 && acc_q.size() > acc_base + 5)
      checkOutput({tag, ":hdr_to_pixel0_cycles"}, 64'(acc_q[acc_base+5].cyc - acc_q[acc_base+4].cyc), 64'(2));
    for (int k = 0; k < sent_pix && k < n_obs && acc_base + 5 + k < acc_q.size(); k++) begin
      obs  = (64'(wr_q[wr_base+k].cyc) << 32) | (64'(wr_q[wr_base+k].addr) << 8) | 64'(wr_q[wr_base+k].data);
      expv = (64'(acc_q[acc_base+5+k].cyc + 1) << 32) | ((64'(BASE) + 64'(k)) << 8) | 64'(pix[k]);
      checkOutput({tag, ":write"}, obs, expv);
    end
  endtask

  initial begin
    int wr_base;
    rst            = 1'b1;
    dut_if.s_data  = 8'd0;
    dut_if.s_valid = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset:s_ready", 64'(dut_if.s_ready), 64'(1));
    checkOutput("reset:mem_we", 64'(dut_if.mem_we), 64'(0));
    checkOutput("reset:o_busy", 64'(o_busy), 64'(0));
    checkOutput("reset:o_err", 64'(o_err), 64'(0));
    checkOutput("reset:o_byte_count", 64'(o_byte_count), 64'(0));
    rst = 1'b0;
    idle(2);
    check_status("after_reset");

    $display("[TB] directed 2x2 frame and bad checksum");
    fixed_pix = '{8'h10, 8'h20, 8'h30, 8'h40};
    applyStimulus("frame_2x2", 2, 2, 8'h00, 0, -1, 0);
    fixed_pix = '{8'h10, 8'h20, 8'h30, 8'h40};
    applyStimulus("bad_csum_a1", 2, 2, 8'h01, 0, -1, 0);

    $display("[TB] header and size errors");
    applyStimulus("width_1025", 1025, 1, 8'h00, 0, -1, 0);
    applyStimulus("recover_3x5", 3, 5, 8'h00, 2, -1, 0);
    applyStimulus("size_1024x1024", 1024, 1024, 8'h00, 0, -1, 0);

    $display("[TB] inter-byte gap timeout");
    applyStimulus("timeout", 2, 2, 8'h00, 0, 3, GAP);
    applyStimulus("byte_on_expiry", 2, 2, 8'h00, 0, 3, GAP - 1);

    $display("[TB] random frames");
    for (int r = 0; r < 6; r++) begin
      applyStimulus("random", $urandom_range(1, 12), $urandom_range(1, 12),
                    ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00, 3, -1, 0);
    end

    $display("[TB] garbage then 64x64 frame");
    do_reset();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    exp_bytes += 3;
    applyStimulus("frame_64x64", 64, 64, 8'h00, 0, -1, 0);
    checkOutput("byte_count_64x64", 64'(o_byte_count), 64'(3 + 5 + 4096 + 1));

    $display("[TB] reset mid-payload");
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    send_byte(8'hA5);
    send_byte(8'h08);
    send_byte(8'h00);
    send_byte(8'h08);
    send_byte(8'h00);
    wr_base = wr_q.size();
    for (int k = 0; k < 10; k++) send_byte(8'($urandom_range(0, 255)));
    rst = 1'b1;
    #1;
    checkOutput("rst_cycle:mem_we", 64'(dut_if.mem_we), 64'(0));
    @(posedge clk);
    #1;
    checkOutput("rst_next:s_ready", 64'(dut_if.s_ready), 64'(1));
    checkOutput("rst_next:mem_we", 64'(dut_if.mem_we), 64'(0));
    checkOutput("rst_next:mem_addr", 64'(dut_if.mem_addr), 64'(0));
    checkOutput("rst_next:mem_wdata", 64'(dut_if.mem_wdata), 64'(0));
    checkOutput("rst_next:o_in_w", 64'(o_in_w), 64'(0));
    checkOutput("rst_next:o_in_h", 64'(o_in_h), 64'(0));
    checkOutput("rst_next:o_img_valid", 64'(o_img_valid), 64'(0));
    checkOutput("rst_next:load_done", 64'(load_done), 64'(0));
    checkOutput("rst_next:o_busy", 64'(o_busy), 64'(0));
    checkOutput("rst_next:o_err", 64'(o_err), 64'(0));
    checkOutput("rst_next:o_byte_count", 64'(o_byte_count), 64'(0));
    checkOutput("rst_mid_payload:write_count", 64'(wr_q.size() - wr_base), 64'(9));
    rst = 1'b0;
    model_reset();
    idle(3);
    check_status("after_mid_rst");
    applyStimulus("post_rst_4x3", 4, 3, 8'h00, 1, -1, 0);

    idle(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
